// File: rtl/nios_cpu_div_pkg.sv
// Shared constants and state encoding for the Nios II iterative divider.
package nios_cpu_div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    localparam logic [DIV_W-1:0] DIV_DZ_Q = {DIV_W{1'b1}};

endpackage

// File: rtl/nios_cpu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor when it fits.
module nios_cpu_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              dvd_msb_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_bit_o
);

    // One extra bit so divisors above 2^(DATA_W-1) still compare correctly.
    logic [DATA_W:0] partial;

    always_comb begin
        partial = {rem_i, dvd_msb_i};
        q_bit_o = (partial >= {1'b0, divisor_i});
        rem_o   = q_bit_o ? (partial[DATA_W-1:0] - divisor_i) : partial[DATA_W-1:0];
    end

endmodule

// File: rtl/nios_cpu_div_cell.sv
// Iterative radix-2 restoring divider for Nios II div/divu.
// Fixed 33-cycle latency: DATA_W shift/subtract steps plus one sign-fix cycle.
module nios_cpu_div_cell
    import nios_cpu_div_pkg::*;
#(
    parameter int DATA_W = DIV_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    input  logic              E_div_abort,
    output logic              div_busy,
    output logic              div_done,
    output logic [DATA_W-1:0] div_quotient,
    output logic [DATA_W-1:0] div_remainder
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    dvd_q, dvd_d;
    logic [DATA_W-1:0]    dvs_q, dvs_d;
    logic [DATA_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]    src1_q, src1_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic                 dz_q, dz_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DATA_W-1:0]    quot_q, quot_d;
    logic [DATA_W-1:0]    remd_q, remd_d;

    logic [DATA_W-1:0]    step_rem;
    logic                 step_qbit;

    function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    nios_cpu_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[DATA_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        src1_d  = src1_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remd_d  = remd_q;

        case (state_q)
            DIV_IDLE: begin
                if (E_div_start && !E_div_abort) begin
                    state_d = DIV_ITER;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    rem_d   = '0;
                    src1_d  = E_src1;
                    dvd_d   = (E_div_signed && E_src1[DATA_W-1]) ? twos_neg(E_src1) : E_src1;
                    dvs_d   = (E_div_signed && E_src2[DATA_W-1]) ? twos_neg(E_src2) : E_src2;
                    q_neg_d = E_div_signed & (E_src1[DATA_W-1] ^ E_src2[DATA_W-1]);
                    r_neg_d = E_div_signed & E_src1[DATA_W-1];
                    dz_d    = (E_src2 == '0);
                end
            end
            DIV_ITER: begin
                if (E_div_abort) begin
                    state_d = DIV_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    // Quotient bits shift into the dividend register as it empties.
                    rem_d = step_rem;
                    dvd_d = {dvd_q[DATA_W-2:0], step_qbit};
                    cnt_d = cnt_q + DIV_CNT_W'(1);
                    if (cnt_q == DIV_CNT_W'(DATA_W - 1)) begin
                        state_d = DIV_FIX;
                    end
                end
            end
            DIV_FIX: begin
                state_d = DIV_IDLE;
                busy_d  = 1'b0;
                if (!E_div_abort) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        quot_d = DATA_W'(DIV_DZ_Q);
                        remd_d = src1_q;
                    end else begin
                        quot_d = q_neg_q ? twos_neg(dvd_q) : dvd_q;
                        remd_d = r_neg_q ? twos_neg(rem_q) : rem_q;
                    end
                end
            end
            default: begin
                state_d = DIV_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            src1_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            src1_q  <= src1_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
        end
    end

    assign div_busy      = busy_q;
    assign div_done      = done_q;
    assign div_quotient  = quot_q;
    assign div_remainder = remd_q;

endmodule

// File: tb/tb_nios_cpu_div_cell.sv
// Directed and randomized bench for nios_cpu_div_cell with an arithmetic reference model.
module tb_nios_cpu_div_cell;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] E_src1;
    logic [31:0] E_src2;
    logic        E_div_start;
    logic        E_div_signed;
    logic        E_div_abort;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    always #5 clk = ~clk;

    nios_cpu_div_cell dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .E_src1        (E_src1),
        .E_src2        (E_src2),
        .E_div_start   (E_div_start),
        .E_div_signed  (E_div_signed),
        .E_div_abort   (E_div_abort),
        .div_busy      (div_busy),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: truncating division from plain integer arithmetic.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        E_src1       = a;
        E_src2       = b;
        E_div_signed = sgn;
        E_div_start  = 1'b1;
        tick();
        E_div_start  = 1'b0;
        E_src1       = $urandom;
        E_src2       = $urandom;
        E_div_signed = 1'($urandom_range(0, 1));
        check({tag, "_busy_e0"}, {31'b0, div_busy}, 32'd1);
        check({tag, "_done_e0"}, {31'b0, div_done}, 32'd0);
    endtask

    // Runs E0+1..E0+33 of an accepted op; pulse_at>0 drives a stray start mid-run.
    task automatic finish_op(input string tag, input logic [31:0] eq, input logic [31:0] er, input int pulse_at);
        int   busy_cycles = 1;
        int   done_cycles = 0;
        logic held_ok     = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            if (i == pulse_at) begin
                E_src1       = 32'd7;
                E_src2       = 32'd7;
                E_div_signed = 1'b0;
                E_div_start  = 1'b1;
            end
            tick();
            E_div_start = 1'b0;
            busy_cycles += int'(div_busy);
            done_cycles += int'(div_done);
            if (div_quotient !== last_q || div_remainder !== last_r) held_ok = 1'b0;
        end
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
        check({tag, "_early_done"}, 32'(done_cycles), 32'd0);
        check({tag, "_held"}, {31'b0, held_ok}, 32'd1);
        tick();
        check({tag, "_done"}, {31'b0, div_done}, 32'd1);
        check({tag, "_busy_end"}, {31'b0, div_busy}, 32'd0);
        check({tag, "_q"}, div_quotient, eq);
        check({tag, "_r"}, div_remainder, er);
        last_q = eq;
        last_r = er;
    endtask

    task automatic done_falls(input string tag);
        tick();
        check({tag, "_done_fall"}, {31'b0, div_done}, 32'd0);
        check({tag, "_q_hold"}, div_quotient, last_q);
        check({tag, "_r_hold"}, div_remainder, last_r);
    endtask

    initial begin
        logic [31:0] a, b, q, r;
        logic        sgn;
        int          dcnt;

        reset_n      = 1'b0;
        E_src1       = '0;
        E_src2       = '0;
        E_div_start  = 1'b0;
        E_div_signed = 1'b0;
        E_div_abort  = 1'b0;
        repeat (2) tick();
        check("rst_busy", {31'b0, div_busy}, 32'd0);
        check("rst_done", {31'b0, div_done}, 32'd0);
        check("rst_q", div_quotient, 32'd0);
        check("rst_r", div_remainder, 32'd0);
        reset_n = 1'b1;
        tick();

        start_op("u100_7", 32'd100, 32'd7, 1'b0);
        finish_op("u100_7", 32'd14, 32'd2, 0);
        done_falls("u100_7");

        start_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        finish_op("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        done_falls("s_m7_2");
        start_op("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        finish_op("u_m7_2", 32'h7FFF_FFFC, 32'd1, 0);
        done_falls("u_m7_2");

        start_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        finish_op("s_ovf", 32'h8000_0000, 32'd0, 0);
        done_falls("s_ovf");
        start_op("u_dz", 32'h1234_5678, 32'd0, 1'b0);
        finish_op("u_dz", 32'hFFFF_FFFF, 32'h1234_5678, 0);
        done_falls("u_dz");
        start_op("s_dz", 32'h8000_0005, 32'd0, 1'b1);
        finish_op("s_dz", 32'hFFFF_FFFF, 32'h8000_0005, 0);
        done_falls("s_dz");

        // Abort mid-ITER, then a fresh op one cycle later.
        start_op("abort", 32'd1000, 32'd3, 1'b0);
        repeat (10) tick();
        E_div_abort = 1'b1;
        tick();
        E_div_abort = 1'b0;
        check("abort_busy", {31'b0, div_busy}, 32'd0);
        check("abort_done", {31'b0, div_done}, 32'd0);
        check("abort_q", div_quotient, last_q);
        check("abort_r", div_remainder, last_r);
        start_op("after_abort", 32'd9, 32'd4, 1'b0);
        finish_op("after_abort", 32'd2, 32'd1, 0);
        done_falls("after_abort");

        // Abort while in the sign-fix cycle suppresses the result.
        start_op("abort_fix", 32'd77, 32'd5, 1'b0);
        repeat (32) tick();
        E_div_abort = 1'b1;
        tick();
        E_div_abort = 1'b0;
        check("abort_fix_busy", {31'b0, div_busy}, 32'd0);
        check("abort_fix_done", {31'b0, div_done}, 32'd0);
        check("abort_fix_q", div_quotient, last_q);

        // Abort and start together in IDLE: nothing accepted.
        E_src1      = 32'd40;
        E_src2      = 32'd8;
        E_div_start = 1'b1;
        E_div_abort = 1'b1;
        tick();
        E_div_start = 1'b0;
        E_div_abort = 1'b0;
        check("abort_start_busy", {31'b0, div_busy}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            dcnt += int'(div_done) + int'(div_busy);
        end
        check("abort_start_quiet", 32'(dcnt), 32'd0);

        // Stray start mid-run ignored, then back-to-back start in the done cycle.
        start_op("ign", 32'd50, 32'd5, 1'b0);
        finish_op("ign", 32'd10, 32'd0, 5);
        start_op("b2b", 32'd1234567, 32'd89, 1'b0);
        finish_op("b2b", 32'd13871, 32'd48, 0);
        done_falls("b2b");

        // Asynchronous reset in the middle of ITER.
        start_op("arst", 32'd12345, 32'd7, 1'b0);
        repeat (10) tick();
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, div_busy}, 32'd0);
        check("arst_done", {31'b0, div_done}, 32'd0);
        check("arst_q", div_quotient, 32'd0);
        check("arst_r", div_remainder, 32'd0);
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        start_op("post_rst", 32'd6, 32'd3, 1'b0);
        finish_op("post_rst", 32'd2, 32'd0, 0);
        done_falls("post_rst");

        // Randomized operands, alternating gaps and back-to-back issue.
        for (int n = 0; n < 24; n++) begin
            a   = $urandom;
            b   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = b | 32'h8000_0000;
                default: ;
            endcase
            ref_div(a, b, sgn, q, r);
            start_op($sformatf("rand%0d", n), a, b, sgn);
            finish_op($sformatf("rand%0d", n), q, r, 0);
            if (n % 2 == 1) done_falls($sformatf("rand%0d", n));
        end
        done_falls("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
